alu_seq_ctrl: RTL and testbench

Multi-cycle control FSM for the single-issue ALU/regfile/RAM datapath. It accepts one 32-bit RV32I instruction per handshake and decodes it. It then sequences the datapath through DECODE, EXECUTE, MEM and WRITEBACK by driving the regfile, operand-mux, ALU, RAM, result-mux and PC-update controls. It sits between the instruction fetch unit and the ALU datapath top level and is the only source of those control signals.

---
 rtl/alu_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle RV32I control sequencer for the ALU/regfile/RAM datapath.
// The sequence is IDLE -> DECODE -> EXECUTE -> [MEM -> [MEM2]] -> [WB] -> IDLE.
// Optional feature macro: ALU_SEQ_CTRL_LOAD_WAIT_EN adds the MEM2 state, which gives
// loads an extra cycle for a registered RAM read.
// fsm_state exposes the current state encoding so it can be observed.
module alu_seq_ctrl #(
    parameter int Data_Width            = 32,
    parameter int Address_Width_RegFile = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [Data_Width-1:0]            instr,
    input  logic                             instr_valid,
    output logic                             instr_ready,
    input  logic                             eq,
    output logic [Address_Width_RegFile-1:0] rs1,
    output logic [Address_Width_RegFile-1:0] rs2,
    output logic [Address_Width_RegFile-1:0] rd,
    output logic [Data_Width-1:0]            ImmOp,
    output logic                             regFileWen,
    output logic                             ALUSrc,
    output logic [3:0]                       ALU_ctrl,
    output logic                             MemWrite,
    output logic [1:0]                       dataType,
    output logic                             SrcSel,
    output logic                             JumpSel,
    output logic                             pc_en,
    output logic [1:0]                       pc_src,
    output logic                             illegal,
    output logic [2:0]                       fsm_state
);

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
    // instr_ready is high only in IDLE and never while rst is high. instr_valid may stay
    // high indefinitely, and the controller takes a new word only after it is back in IDLE.

`ifdef ALU_SEQ_CTRL_LOAD_WAIT_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2, S_MEM = 3'd3, S_MEM2 = 3'd4, S_WB = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2, S_MEM = 3'd3, S_WB = 3'd5
    } state_t;
`endif

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_PASS = 4'b1010;

    state_t      state, state_nx;
    logic [31:0] ir;
    logic [Data_Width-1:0] imm_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal, is_load, is_store, is_branch, is_bne, is_jal, is_jalr, is_byte;
    logic        dec_alu_src;
    logic [3:0]  dec_alu_op;
    logic [31:0] imm32;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7    = ir[31:25];
    assign rs1       = ir[19:15];
    assign rs2       = ir[24:20];
    assign rd        = ir[11:7];
    assign ImmOp     = imm_q;
    assign fsm_state = state;

    // Decode of the held IR. The IR is stable for the whole instruction, so the outputs
    // derived from it stay Moore-style.
    always_comb begin
        legal       = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_branch   = 1'b0;
        is_bne      = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        is_byte     = 1'b0;
        dec_alu_src = 1'b0;
        dec_alu_op  = OP_ADD;
        imm32       = 32'd0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (funct3)
                        3'b000:  dec_alu_op = OP_ADD;
                        3'b001:  dec_alu_op = OP_SLL;
                        3'b010:  dec_alu_op = OP_SLT;
                        3'b011:  dec_alu_op = OP_SLTU;
                        3'b100:  dec_alu_op = OP_XOR;
                        3'b101:  dec_alu_op = OP_SRL;
                        3'b110:  dec_alu_op = OP_OR;
                        default: dec_alu_op = OP_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal      = 1'b1;
                    dec_alu_op = OP_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    legal      = 1'b1;
                    dec_alu_op = OP_SRA;
                end
            end
            7'b0010011: begin
                dec_alu_src = 1'b1;
                imm32       = {{20{ir[31]}}, ir[31:20]};
                legal       = 1'b1;
                case (funct3)
                    3'b000: dec_alu_op = OP_ADD;
                    3'b010: dec_alu_op = OP_SLT;
                    3'b011: dec_alu_op = OP_SLTU;
                    3'b100: dec_alu_op = OP_XOR;
                    3'b110: dec_alu_op = OP_OR;
                    3'b111: dec_alu_op = OP_AND;
                    3'b001: begin
                        imm32      = {27'd0, ir[24:20]};
                        dec_alu_op = OP_SLL;
                        legal      = (funct7 == 7'b0000000);
                    end
                    default: begin
                        imm32      = {27'd0, ir[24:20]};
                        dec_alu_op = (funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
                        legal      = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                endcase
            end
            7'b0110111: begin
                legal       = 1'b1;
                dec_alu_src = 1'b1;
                dec_alu_op  = OP_PASS;
                imm32       = {ir[31:12], 12'd0};
            end
            7'b1101111: begin
                legal       = 1'b1;
                is_jal      = 1'b1;
                dec_alu_src = 1'b1;
                imm32       = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            7'b1100111: begin
                legal       = (funct3 == 3'b000);
                is_jalr     = 1'b1;
                dec_alu_src = 1'b1;
                imm32       = {{20{ir[31]}}, ir[31:20]};
            end
            7'b0000011: begin
                legal       = (funct3 == 3'b010) || (funct3 == 3'b100);
                is_load     = 1'b1;
                is_byte     = (funct3 == 3'b100);
                dec_alu_src = 1'b1;
                imm32       = {{20{ir[31]}}, ir[31:20]};
            end
            7'b0100011: begin
                legal       = (funct3 == 3'b010) || (funct3 == 3'b000);
                is_store    = 1'b1;
                is_byte     = (funct3 == 3'b000);
                dec_alu_src = 1'b1;
                imm32       = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            7'b1100011: begin
                legal      = (funct3 == 3'b000) || (funct3 == 3'b001);
                is_branch  = 1'b1;
                is_bne     = (funct3 == 3'b001);
                dec_alu_op = OP_SUB;
                imm32      = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            default: legal = 1'b0;
        endcase
    end

    // State, instruction register and immediate register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ir    <= 32'd0;
            imm_q <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && instr_valid)
                ir <= instr[31:0];
            if (state == S_DECODE)
                imm_q <= Data_Width'(signed'(imm32));
        end
    end

    // Next-state and control outputs. The strobes are forced low while rst is high, so
    // an abandoned instruction never writes anything.
    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        regFileWen  = 1'b0;
        ALUSrc      = 1'b0;
        ALU_ctrl    = OP_ADD;
        MemWrite    = 1'b0;
        dataType    = 2'b00;
        SrcSel      = 1'b0;
        JumpSel     = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 2'b00;
        illegal     = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nx = S_DECODE;
            end
            S_DECODE: begin
                illegal  = !legal;
                state_nx = legal ? S_EXECUTE : S_IDLE;
            end
            S_EXECUTE: begin
                ALUSrc   = dec_alu_src;
                ALU_ctrl = dec_alu_op;
                if (is_branch) begin
                    pc_en    = 1'b1;
                    pc_src   = (is_bne ? !eq : eq) ? 2'b01 : 2'b00;
                    state_nx = S_IDLE;
                end else if (is_load || is_store) begin
                    state_nx = S_MEM;
                end else begin
                    state_nx = S_WB;
                end
            end
            S_MEM: begin
                ALUSrc   = dec_alu_src;
                ALU_ctrl = dec_alu_op;
                dataType = {1'b0, is_byte};
                if (is_store) begin
                    MemWrite = 1'b1;
                    pc_en    = 1'b1;
                    state_nx = S_IDLE;
                end else begin
`ifdef ALU_SEQ_CTRL_LOAD_WAIT_EN
                    state_nx = S_MEM2;
`else
                    state_nx = S_WB;
`endif
                end
            end
`ifdef ALU_SEQ_CTRL_LOAD_WAIT_EN
            S_MEM2: begin
                ALUSrc   = dec_alu_src;
                ALU_ctrl = dec_alu_op;
                dataType = {1'b0, is_byte};
                state_nx = S_WB;
            end
`endif
            S_WB: begin
                ALUSrc     = dec_alu_src;
                ALU_ctrl   = dec_alu_op;
                dataType   = {1'b0, is_byte};
                regFileWen = (rd != '0);
                SrcSel     = is_load;
                JumpSel    = is_jal || is_jalr;
                pc_en      = 1'b1;
                pc_src     = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (rst) begin
            instr_ready = 1'b0;
            regFileWen  = 1'b0;
            MemWrite    = 1'b0;
            pc_en       = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vector table plus hand-written reset and back-to-back sequences.
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_CTRL_LOAD_WAIT_EN
    localparam int LW = 1;
`else
    localparam int LW = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        eq;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] ImmOp;
    logic        regFileWen, ALUSrc, MemWrite, SrcSel, JumpSel, pc_en, illegal;
    logic [3:0]  ALU_ctrl;
    logic [1:0]  dataType, pc_src;
    logic [2:0]  fsm_state;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_ctrl dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .eq(eq), .rs1(rs1), .rs2(rs2), .rd(rd),
        .ImmOp(ImmOp), .regFileWen(regFileWen), .ALUSrc(ALUSrc), .ALU_ctrl(ALU_ctrl),
        .MemWrite(MemWrite), .dataType(dataType), .SrcSel(SrcSel), .JumpSel(JumpSel),
        .pc_en(pc_en), .pc_src(pc_src), .illegal(illegal), .fsm_state(fsm_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Expected cycle numbers are relative to the handshake edge N (1 = N+1); 0 = never.
    typedef struct {
        logic [31:0] ins;
        logic        e;
        int          ill;
        int          wen;
        int          mw;
        int          pc;
        logic [1:0]  psrc;
        int          rdy;
        logic [3:0]  alu;
        logic        asrc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        ssel;
        logic        jsel;
        logic [1:0]  dt;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_quiet(input string name, input int idx);
        chk({name, "_outs"}, idx,
            {2'b00, ImmOp, rs1, rs2, rd, regFileWen, ALUSrc, ALU_ctrl, MemWrite,
             dataType, SrcSel, JumpSel, pc_en, pc_src, illegal}, 64'd0);
        chk({name, "_ready"}, idx, 64'(instr_ready), 64'd1);
    endtask

    // Present one instruction, complete the handshake, then observe eight cycles.
    task automatic run_vec(input vec_t v, input int idx);
        int ill_c, wen_c, mw_c, pc_c, rdy_c, pulses, wait_n, exp_pulses;
        logic [1:0]  ps, dts;
        logic [3:0]  alu2;
        logic        asrc2, ss, js;
        logic [31:0] imm2;
        logic [4:0]  rd1;
        ill_c = 0; wen_c = 0; mw_c = 0; pc_c = 0; rdy_c = 0; pulses = 0; wait_n = 0;
        ps = 2'b00; dts = 2'b00; alu2 = 4'h0; asrc2 = 1'b0; ss = 1'b0; js = 1'b0;
        imm2 = 32'd0; rd1 = 5'd0;
        @(negedge clk);
        instr = v.ins; eq = v.e; instr_valid = 1'b1;
        while (!instr_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        if (!instr_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL handshake (vec %0d): got instr_ready 0, expected 1 within 20 cycles", idx);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            pulses += int'(illegal) + int'(regFileWen) + int'(MemWrite) + int'(pc_en);
            if (illegal    && ill_c == 0) ill_c = k;
            if (regFileWen && wen_c == 0) wen_c = k;
            if (MemWrite   && mw_c  == 0) mw_c  = k;
            if (pc_en      && pc_c  == 0) pc_c  = k;
            if (instr_ready && rdy_c == 0) rdy_c = k;
            if (k == 1) rd1 = rd;
            if (k == 2) begin
                alu2 = ALU_ctrl; asrc2 = ALUSrc; imm2 = ImmOp;
            end
            if (k == v.pc) begin
                ps = pc_src; ss = SrcSel; js = JumpSel; dts = dataType;
            end
        end
        exp_pulses = int'(v.ill != 0) + int'(v.wen != 0) + int'(v.mw != 0) + int'(v.pc != 0);
        chk("illegal_cycle", idx, 64'(ill_c), 64'(v.ill));
        chk("wen_cycle",     idx, 64'(wen_c), 64'(v.wen));
        chk("memwrite_cycle", idx, 64'(mw_c), 64'(v.mw));
        chk("pc_en_cycle",   idx, 64'(pc_c),  64'(v.pc));
        chk("ready_cycle",   idx, 64'(rdy_c), 64'(v.rdy));
        chk("pulse_count",   idx, 64'(pulses), 64'(exp_pulses));
        chk("rd",            idx, 64'(rd1),   64'(v.rd));
        if (v.ill == 0) begin
            chk("alu_ctrl", idx, 64'(alu2),  64'(v.alu));
            chk("alu_src",  idx, 64'(asrc2), 64'(v.asrc));
            chk("imm",      idx, 64'(imm2),  64'(v.imm));
        end
        if (v.pc != 0) begin
            chk("pc_src",   idx, 64'(ps),  64'(v.psrc));
            chk("src_sel",  idx, 64'(ss),  64'(v.ssel));
            chk("jump_sel", idx, 64'(js),  64'(v.jsel));
            chk("data_type", idx, 64'(dts), 64'(v.dt));
        end
    endtask

    initial begin
        logic strobe_any;
        logic [7:0] pc_mask, rdy_mask;

        //            ins           e     ill wen    mw pc     psrc  rdy    alu    asrc  imm            rd     ss    js    dt
        vecs[0]  = '{32'h00700293, 1'b0, 0, 3,      0, 3,      2'd0, 4,      4'h0, 1'b1, 32'd7,         5'd5,  1'b0, 1'b0, 2'd0}; // addi x5,x0,7
        vecs[1]  = '{32'hFE208CE3, 1'b1, 0, 0,      0, 2,      2'd1, 3,      4'h1, 1'b0, 32'hFFFFFFF8,  5'd25, 1'b0, 1'b0, 2'd0}; // beq taken
        vecs[2]  = '{32'hFE208CE3, 1'b0, 0, 0,      0, 2,      2'd0, 3,      4'h1, 1'b0, 32'hFFFFFFF8,  5'd25, 1'b0, 1'b0, 2'd0}; // beq not taken
        vecs[3]  = '{32'hFE209CE3, 1'b1, 0, 0,      0, 2,      2'd0, 3,      4'h1, 1'b0, 32'hFFFFFFF8,  5'd25, 1'b0, 1'b0, 2'd0}; // bne not taken
        vecs[4]  = '{32'hFE209CE3, 1'b0, 0, 0,      0, 2,      2'd1, 3,      4'h1, 1'b0, 32'hFFFFFFF8,  5'd25, 1'b0, 1'b0, 2'd0}; // bne taken
        vecs[5]  = '{32'h0030C303, 1'b0, 0, 4 + LW, 0, 4 + LW, 2'd0, 5 + LW, 4'h0, 1'b1, 32'd3,         5'd6,  1'b1, 1'b0, 2'd1}; // lbu x6,3(x1)
        vecs[6]  = '{32'h00812383, 1'b0, 0, 4 + LW, 0, 4 + LW, 2'd0, 5 + LW, 4'h0, 1'b1, 32'd8,         5'd7,  1'b1, 1'b0, 2'd0}; // lw x7,8(x2)
        vecs[7]  = '{32'h0020A023, 1'b0, 0, 0,      3, 3,      2'd0, 4,      4'h0, 1'b1, 32'd0,         5'd0,  1'b0, 1'b0, 2'd0}; // sw x2,0(x1)
        vecs[8]  = '{32'h002082A3, 1'b0, 0, 0,      3, 3,      2'd0, 4,      4'h0, 1'b1, 32'd5,         5'd5,  1'b0, 1'b0, 2'd1}; // sb x2,5(x1)
        vecs[9]  = '{32'h010000EF, 1'b0, 0, 3,      0, 3,      2'd1, 4,      4'h0, 1'b1, 32'd16,        5'd1,  1'b0, 1'b1, 2'd0}; // jal x1,16
        vecs[10] = '{32'h00008067, 1'b0, 0, 0,      0, 3,      2'd2, 4,      4'h0, 1'b1, 32'd0,         5'd0,  1'b0, 1'b1, 2'd0}; // jalr x0,0(x1)
        vecs[11] = '{32'h00208033, 1'b0, 0, 0,      0, 3,      2'd0, 4,      4'h0, 1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 2'd0}; // add x0,x1,x2
        vecs[12] = '{32'h402081B3, 1'b0, 0, 3,      0, 3,      2'd0, 4,      4'h1, 1'b0, 32'd0,         5'd3,  1'b0, 1'b0, 2'd0}; // sub x3,x1,x2
        vecs[13] = '{32'h12345537, 1'b0, 0, 3,      0, 3,      2'd0, 4,      4'hA, 1'b1, 32'h12345000,  5'd10, 1'b0, 1'b0, 2'd0}; // lui x10,0x12345
        vecs[14] = '{32'h4030D213, 1'b0, 0, 3,      0, 3,      2'd0, 4,      4'h7, 1'b1, 32'd3,         5'd4,  1'b0, 1'b0, 2'd0}; // srai x4,x1,3
        vecs[15] = '{32'h4230D213, 1'b0, 1, 0,      0, 0,      2'd0, 2,      4'h0, 1'b0, 32'd0,         5'd4,  1'b0, 1'b0, 2'd0}; // bad shift funct7
        vecs[16] = '{32'h0000007F, 1'b0, 1, 0,      0, 0,      2'd0, 2,      4'h0, 1'b0, 32'd0,         5'd0,  1'b0, 1'b0, 2'd0}; // opcode 0x7F
        vecs[17] = '{32'h40309213, 1'b0, 1, 0,      0, 0,      2'd0, 2,      4'h0, 1'b0, 32'd0,         5'd4,  1'b0, 1'b0, 2'd0}; // slli, funct7 0100000
        vecs[18] = '{32'h0020A2B3, 1'b0, 0, 3,      0, 3,      2'd0, 4,      4'h8, 1'b0, 32'd0,         5'd5,  1'b0, 1'b0, 2'd0}; // slt x5,x1,x2
        vecs[19] = '{32'hFFF0C293, 1'b0, 0, 3,      0, 3,      2'd0, 4,      4'h4, 1'b1, 32'hFFFFFFFF,  5'd5,  1'b0, 1'b0, 2'd0}; // xori x5,x1,-1
        vecs[20] = '{32'h4020C0B3, 1'b0, 1, 0,      0, 0,      2'd0, 2,      4'h0, 1'b0, 32'd0,         5'd1,  1'b0, 1'b0, 2'd0}; // R funct7 0100000, f3 100

        // Reset state.
        rst = 1'b1; instr = 32'd0; instr_valid = 1'b0; eq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_hold_outs", 0,
            {2'b00, ImmOp, rs1, rs2, rd, regFileWen, ALUSrc, ALU_ctrl, MemWrite,
             dataType, SrcSel, JumpSel, pc_en, pc_src, illegal}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("after_reset", 0);

        // Vector table.
        for (int i = 0; i < 21; i++) run_vec(vecs[i], i);

        // Reset during EXECUTE of a store: the store never reaches memory.
        @(negedge clk);
        instr = 32'h0020A023; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        strobe_any = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            strobe_any |= MemWrite | pc_en | regFileWen;
            if (k == 1) chk_quiet("rst_exec", 100);
        end
        chk("rst_exec_strobes", 100, 64'(strobe_any), 64'd0);

        // Reset in the MEM cycle of a store: the write strobe is suppressed immediately.
        @(negedge clk);
        instr = 32'h0020A023; instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mem_before_rst", 101, 64'(MemWrite), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mem_strobes", 101, 64'({MemWrite, pc_en, regFileWen}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("rst_mem", 101);

        // instr_valid held high: the next addi is taken only once the controller is back in IDLE.
        @(negedge clk);
        instr = 32'h00700293; instr_valid = 1'b1;
        @(posedge clk);
        pc_mask = 8'd0; rdy_mask = 8'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            pc_mask[k-1]  = pc_en;
            rdy_mask[k-1] = instr_ready;
            if (k == 8) instr_valid = 1'b0;
        end
        chk("b2b_pc_en", 102, 64'(pc_mask), 64'(8'b0100_0100));
        chk("b2b_ready", 102, 64'(rdy_mask), 64'(8'b1000_1000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
